// File: rtl/uart_hex_sender.sv
// uart_hex_sender: prints a binary word as uppercase ASCII hex, most
// significant digit first, one byte at a time into uart_tx.
//
// Ports:
//   mclk         system clock, all logic on the rising edge
//   reset_n      synchronous reset, active-low
//   word         value to print, latched when word_strobe is accepted
//   word_strobe  one-cycle print request (accepted only in IDLE)
//   busy         high while a word is being sent
//   done         one-cycle pulse as the last byte of a word finishes
//   dropped      sticky flag: a word_strobe arrived while busy
//   tx_data      byte to uart_tx.data
//   tx_strobe    one-cycle pulse to uart_tx.data_strobe
//   tx_ready     uart_tx.ready, high when the transmitter is idle
//
// Build option: define UART_HEX_CRLF_EN to append CR (0x0D) and LF (0x0A)
// after the digits of every word.
module uart_hex_sender #(
    parameter int NDIGITS = 4
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic [4*NDIGITS-1:0] word,
    input  logic                 word_strobe,
    output logic                 busy,
    output logic                 done,
    output logic                 dropped,
    output logic [7:0]           tx_data,
    output logic                 tx_strobe,
    input  logic                 tx_ready
);

    localparam int W = 4 * NDIGITS;
`ifdef UART_HEX_CRLF_EN
    localparam int NBYTES = NDIGITS + 2;
`else
    localparam int NBYTES = NDIGITS;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_ACK, WAIT_DONE} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] shreg, shreg_nxt;
    logic [3:0]   cnt, cnt_nxt;   // sized for up to 10 bytes per word
    logic [7:0]   tx_data_nxt;
    logic         last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        // 'A' - 10 = 8'h37
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte for a given position; digits always come from the top nibble
    // because the shift register moves the next digit up after each byte.
    function automatic logic [7:0] byte_for(input logic [W-1:0] sr, input logic [3:0] c);
`ifdef UART_HEX_CRLF_EN
        if (c == 4'(NDIGITS))
            return 8'h0D;
        if (c > 4'(NDIGITS))
            return 8'h0A;
`endif
        return hex_char(sr[W-1 -: 4]);
    endfunction

    assign last = (cnt == 4'(NBYTES - 1));
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done      = 1'b0;
        tx_strobe = 1'b0;
        unique case (state)
            IDLE: begin
                if (word_strobe) begin
                    shreg_nxt = word;
                    cnt_nxt   = 4'd0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (tx_ready)
                    state_nxt = STROBE;
            end
            STROBE: begin
                tx_strobe = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!tx_ready)
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (last) begin
                        // busy is still high this cycle, so a word_strobe
                        // coinciding with done is dropped
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        shreg_nxt = shreg << 4;
                        cnt_nxt   = cnt + 4'd1;
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // tx_data is registered so it is already valid in the LOAD cycle
        // and holds its value between bytes and after the word.
        tx_data_nxt = (state_nxt == LOAD) ? byte_for(shreg_nxt, cnt_nxt) : tx_data;
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= 4'd0;
            tx_data <= 8'h00;
            dropped <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            tx_data <= tx_data_nxt;
            if (word_strobe && busy)
                dropped <= 1'b1;
        end
    end

endmodule

// File: doc/uart_hex_sender.md
Name: uart_hex_sender

Overview:
- Formats a binary word as uppercase ASCII hex and streams the characters, one byte at a time, into the existing uart_tx byte transmitter.
- Sits directly upstream of uart_tx and replaces the hand-built {4'h3, digit} data path.
- Any counter or status value can be printed on serial_txd as a readable hex line with a single strobe.

Parameters:
- NDIGITS, 4, number of hex digits sent per word. Legal range 1..8. Input word width is 4*NDIGITS.

Ports:
- mclk  input  1  system clock (12 MHz), all logic on rising edge
- reset_n  input  1  synchronous reset, active-low
- word  input  4*NDIGITS  value to print, sampled on an accepted word_strobe
- word_strobe  input  1  one-cycle request to print word
- busy  output  1  high from the cycle after acceptance until the last byte is finished
- done  output  1  one-cycle pulse when the last byte of a word is finished
- dropped  output  1  sticky; set when word_strobe arrives while busy
- tx_data  output  8  byte to uart_tx.data
- tx_strobe  output  1  one-cycle pulse to uart_tx.data_strobe
- tx_ready  input  1  from uart_tx.ready; high = transmitter idle

Behaviour:
- Reset: the reset is synchronous and active-low; all logic is clocked on mclk. While reset_n=0 at a rising edge of mclk, all of the following are forced:
  - state=IDLE
  - busy=0, done=0, dropped=0
  - tx_strobe=0, tx_data=8'h00
  - internal shift register and byte counter cleared
- Reset mid-word aborts transmission immediately. No further tx_strobe is issued. A byte already handed to uart_tx completes under uart_tx's own control.
- Character map:
  - nibble 0..9 -> 8'h30+n
  - nibble 10..15 -> 8'h41+(n-10), uppercase only
- Digit order: most-significant nibble first. The word is latched into a shift register on acceptance, so changes on word afterwards are ignored.
- Byte count per word: NDIGITS, plus 2 if UART_HEX_CRLF_EN is defined. The byte counter is sized for the maximum of 10.
- FSM states:
  - IDLE: on word_strobe, latch word, clear the counter and go to LOAD. busy rises the next cycle.
  - LOAD: drive tx_data with the current character. Go to STROBE only when tx_ready=1; otherwise stay.
  - STROBE: tx_strobe=1 for exactly this cycle, with tx_data stable. Go to WAIT_ACK.
  - WAIT_ACK: wait for tx_ready=0, i.e. uart_tx has taken the byte. tx_data is held. Go to WAIT_DONE.
  - WAIT_DONE: wait for tx_ready=1. Then:
    - if this was the last byte: go to IDLE, pulse done for 1 cycle, drop busy in the same cycle;
    - otherwise: shift the nibble or advance the counter, and go to LOAD.
- tx_data holds the current byte from LOAD through WAIT_DONE. It is not cleared between bytes.
- At most one tx_strobe is outstanding at any time. No new strobe is issued until tx_ready has gone low and then high again.
- word_strobe during busy: ignored and sets dropped=1. dropped is cleared only by reset.
- word_strobe in the same cycle as done: the block is still busy, so the strobe is dropped and dropped is set.
- word_strobe on the first IDLE cycle after done: accepted.
- Continuous word_strobe=1 in IDLE: the first cycle is accepted; later cycles while busy set dropped.
- Latency: word_strobe accepted at cycle T gives tx_strobe at T+2 at the earliest, when tx_ready=1.

Optional Feature:
- Macro: UART_HEX_CRLF_EN.
- Defined: after the digits, send 8'h0D then 8'h0A using the same LOAD/STROBE/WAIT handshake; done follows the 8'h0A byte.
- Undefined: only the NDIGITS digit bytes are sent; done follows the last digit. No CR/LF logic is generated.

Test Plan:
- NDIGITS=4, word=16'h1A3F, strobe once, bench models uart_tx (ready low for 100 cycles after each strobe) -> tx_data sequence 8'h31, 8'h41, 8'h33, 8'h46 (then 8'h0D, 8'h0A with UART_HEX_CRLF_EN); exactly 4 (or 6) tx_strobe pulses; one done pulse; busy low afterwards.
- word=16'h0000, then 16'hFFFF after done -> 8'h30 x4, then 8'h46 x4; dropped stays 0.
- Second word_strobe with word=16'h1234 while sending 16'h1A3F -> 16'h1234 never transmitted; dropped=1 and stays 1; output identical to the first test.
- tx_ready held low at acceptance for 50 cycles -> no tx_strobe until tx_ready=1; first strobe arrives 1 cycle after LOAD sees ready.
- reset_n=0 for 1 cycle during the 2nd byte -> next edge: busy=0, tx_strobe=0, tx_data=8'h00, dropped=0; a new word_strobe restarts from the MSB digit.
- NDIGITS=1, word=4'hB -> single byte 8'h42; done 1 cycle after tx_ready returns high.
